// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states and a one-cycle ready pulse.
// Optional feature: define MEM_RESPONDER_BOUNDS_CHECK_EN to flag and suppress accesses at address >= DEPTH.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_ready,
    output logic              busy,
    output logic              mem_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state;
    logic [3:0]        waitCnt;
    logic [ADDR_W-1:0] capAddr;
    logic [DATA_W-1:0] capData;
    logic              capWrite;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  memIdx;
    logic              inRange;
    logic              canAccept;
    logic              reqOne;
    logic              reqBoth;
    logic              accessNow;

    assign reqOne    = Read ^ Write;
    assign reqBoth   = Read & Write;
    assign canAccept = (state == IDLE) || (state == DONE);
    assign accessNow = (state == WAIT) && (waitCnt == 4'd0);
    // Modulo keeps non-power-of-two depths inside the array.
    assign memIdx    = IDX_W'(32'(capAddr) % 32'(DEPTH));

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    assign inRange = 32'(capAddr) < 32'(DEPTH);
`else
    assign inRange = 1'b1;
`endif

    // Request capture: inputs only need to be valid on the accepting edge.
    always_ff @(posedge clock) begin
        if (canAccept && reqOne) begin
            capAddr  <= address;
            capData  <= write_data;
            capWrite <= Write;
        end
    end

    // Storage is never reset; a clear on the access edge drops the pending write.
    always_ff @(posedge clock) begin
        if (!clear && accessNow && capWrite && inRange) begin
            mem[memIdx] <= capData;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            Mdatain   <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (reqBoth) begin
                        mem_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (reqOne) begin
                        waitCnt <= 4'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end else begin
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WAIT: begin
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else begin
                        busy      <= 1'b0;
                        mem_ready <= 1'b1;
                        mem_err   <= !inRange;
                        state     <= DONE;
                        if (!capWrite) begin
                            Mdatain <= inRange ? mem[memIdx] : '0;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (DEPTH=300, WAIT_CYCLES=2) against an array-based reference model.
module tb_mem_responder;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 9;
    localparam int DEPTH       = 300;
    localparam int WAIT_CYCLES = 2;

    logic              clock = 1'b0;
    logic              clear = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic              Read = 1'b0;
    logic              Write = 1'b0;
    logic [DATA_W-1:0] Mdatain;
    logic              mem_ready;
    logic              busy;
    logic              mem_err;

    mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clock(clock), .clear(clear), .address(address), .write_data(write_data),
        .Read(Read), .Write(Write), .Mdatain(Mdatain), .mem_ready(mem_ready),
        .busy(busy), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] refMem [DEPTH];
    logic [DATA_W-1:0] refMd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit outOfRange(input int a);
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        return a >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one access at the current negedge and follow it to its ready cycle.
    // Leaves the bench at the negedge of the ready (DONE) cycle.
    task automatic access(input bit isWrite, input int a, input logic [31:0] d, input bit poke);
        logic [31:0] expMd;
        bit expErr;
        expErr = outOfRange(a);
        if (isWrite) begin
            if (!expErr) refMem[a % DEPTH] = d;
            expMd = refMd;
        end else begin
            expMd = expErr ? 32'h0 : refMem[a % DEPTH];
        end
        refMd = expMd;
        address = ADDR_W'(a);
        write_data = d;
        Read = !isWrite;
        Write = isWrite;
        for (int i = 1; i <= WAIT_CYCLES + 1; i++) begin
            @(negedge clock);
            Read = 1'b0;
            Write = 1'b0;
            if (poke && i == 2) begin
                Read = 1'b1;
                address = 9'h007;
            end
            check("busy_in_wait", 32'(busy), 32'd1);
            check("ready_early", 32'(mem_ready), 32'd0);
        end
        @(negedge clock);
        Read = 1'b0;
        Write = 1'b0;
        check("ready_pulse", 32'(mem_ready), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("mdatain", Mdatain, expMd);
        check("err_at_ready", 32'(mem_err), 32'(expErr));
    endtask

    task automatic idle();
        @(negedge clock);
        check("idle_ready", 32'(mem_ready), 32'd0);
        check("idle_err", 32'(mem_err), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_mdatain", Mdatain, refMd);
    endtask

    initial begin
        logic [31:0] prior20;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_mdatain", Mdatain, 32'h0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        clear = 1'b0;

        // Fill storage so every later read has a known value
        for (int a = 0; a < DEPTH; a++) access(1'b1, a, $urandom, 1'b0);
        idle();

        // Write then read, and back-to-back read issued in the DONE cycle
        access(1'b1, 32'h005, 32'hDEADBEEF, 1'b0);
        access(1'b0, 32'h005, 32'h0, 1'b0);
        check("readback_5", Mdatain, 32'hDEADBEEF);
        idle();

        // Read request during WAIT is ignored; only one ready pulse
        access(1'b0, 32'h00A, 32'h0, 1'b1);
        idle();
        idle();

        // Simultaneous Read and Write is rejected
        address = 9'h010;
        write_data = 32'hA5A5A5A5;
        Read = 1'b1;
        Write = 1'b1;
        @(negedge clock);
        Read = 1'b0;
        Write = 1'b0;
        check("both_err", 32'(mem_err), 32'd1);
        check("both_ready", 32'(mem_ready), 32'd0);
        check("both_busy", 32'(busy), 32'd0);
        idle();
        access(1'b0, 32'h010, 32'h0, 1'b0);
        idle();

        // Reset in the second WAIT cycle aborts a write
        prior20 = refMem[32'h020];
        address = 9'h020;
        write_data = 32'h12345678;
        Write = 1'b1;
        @(negedge clock);
        Write = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        refMd = '0;
        check("abort_mdatain", Mdatain, 32'h0);
        check("abort_ready", 32'(mem_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(mem_err), 32'd0);
        access(1'b0, 32'h020, 32'h0, 1'b0);
        check("abort_prior", Mdatain, prior20);
        idle();

        // Address beyond DEPTH: wraps, or flagged when bounds checking is built in
        access(1'b0, 32'h1F0, 32'h0, 1'b0);
        idle();

        // Randomized mix of reads/writes across the full address range
        for (int n = 0; n < 60; n++) begin
            access(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)), $urandom, 1'b0);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
